pattern_stream_serializer: RTL

PATTERN_STREAM_SERIALIZER -- requirements
Module: pattern_stream_serializer

---
 rtl/pattern_stream_serializer_pkg.sv | 8 +
 rtl/sync_word_fifo.sv | 33 +++
 rtl/pattern_stream_serializer.sv | 63 ++++++
 3 files changed

// File: rtl/pattern_stream_serializer_pkg.sv
// pattern_stream_serializer_pkg: shared FSM encodings and default sizes for the serializer
package pattern_stream_serializer_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;
endpackage

// File: rtl/sync_word_fifo.sv
// sync_word_fifo: synchronous word FIFO with extra wrap bit on each pointer
module sync_word_fifo import pattern_stream_serializer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pattern_stream_serializer.sv
// pattern_stream_serializer: buffers parallel words and streams them out bit-serially with optional idle gaps
module pattern_stream_serializer import pattern_stream_serializer_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic             en_i,
    input  logic [3:0]       gap_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             last_o,
    output logic [15:0]      sent_cnt_o
);
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    logic [1:0] state;
    logic [WIDTH-1:0] sreg, nxt, dout;
    logic [BW-1:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic full, empty, push, pop;
    assign wready_o = !rst && !full;
    assign push = wvalid_i && wready_o;
    assign valid_o = !rst && en_i && state == SHIFT;
    assign d_o = valid_o && (MSB_FIRST != 0 ? sreg[WIDTH-1] : sreg[0]);
    assign last_o = valid_o && bit_cnt == LAST_BIT;
    assign nxt = MSB_FIRST != 0 ? sreg << 1 : sreg >> 1;
    // a new word loads from idle, straight after a gap-less last bit, or on the final gap cycle
    assign pop = !rst && en_i && !empty &&
                 (state == IDLE || (last_o && gap_cnt == 4'd0) || (state == GAP && gap_cnt <= 4'd1));
    sync_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din(data_i), .dout(dout), .full(full), .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sent_cnt_o <= '0;
        end else begin
            if (pop) begin
                sreg <= dout;
                bit_cnt <= '0;
                gap_cnt <= gap_i;
                state <= SHIFT;
            end else if (valid_o) begin
                sreg <= nxt;
                bit_cnt <= bit_cnt + 1'b1;
                if (last_o) state <= gap_cnt != 4'd0 ? GAP : IDLE;
            end else if (state == GAP && en_i) begin
                gap_cnt <= gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) state <= IDLE;
            end
            if (last_o) sent_cnt_o <= sent_cnt_o + 16'd1;
        end
    end
endmodule
